// File: rtl/uart_debug_ctrl.sv
// uart_debug_ctrl: host command sequencer between the uart and the core.
// Decodes run/step/dump commands, gates cpu_en, streams a word dump as bytes.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   rx_done, r_data      received-byte pulse and byte from the uart
//   tx_done              uart finished the outstanding byte
//   tx_start, w_data     transmit pulse and byte to the uart
//   cpu_en               core clock-enable
//   cpu_halted           core has retired HALT (level)
//   dump_addr, dump_data word address / synchronous-read word of the dump source
//   busy                 high whenever the sequencer is not idle
module uart_debug_ctrl #(
   parameter int unsigned DUMP_WORDS = 32,
   parameter int unsigned ADDR_BITS  = 5,
   parameter logic [7:0]  TERM_BYTE  = 8'h0A
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_done,
   input  logic [7:0]           r_data,
   input  logic                 tx_done,
   output logic                 tx_start,
   output logic [7:0]           w_data,
   output logic                 cpu_en,
   input  logic                 cpu_halted,
   output logic [ADDR_BITS-1:0] dump_addr,
   input  logic [31:0]          dump_data,
   output logic                 busy
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RUN,
      S_STEP,
      S_RD_ADDR,
      S_RD_WAIT,
      S_SEND,
      S_WAIT_TX,
      S_TERM,
      S_TERM_WAIT
   } state_e;

   localparam logic [7:0] CMD_RUN  = 8'h63;
   localparam logic [7:0] CMD_STEP = 8'h73;
   localparam logic [7:0] CMD_DUMP = 8'h64;
   localparam logic [ADDR_BITS-1:0] LAST_WORD = ADDR_BITS'(DUMP_WORDS - 1);

   state_e               state_q, state_d;
   logic [ADDR_BITS-1:0] word_q, word_d;
   logic [1:0]           byte_q, byte_d;
   logic [31:0]          shift_q, shift_d;
   logic [7:0]           w_data_q, w_data_d;
   logic                 tx_start_q, tx_start_d;
   logic                 cpu_en_q, cpu_en_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         word_q     <= '0;
         byte_q     <= '0;
         shift_q    <= '0;
         w_data_q   <= '0;
         tx_start_q <= 1'b0;
         cpu_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         byte_q     <= byte_d;
         shift_q    <= shift_d;
         w_data_q   <= w_data_d;
         tx_start_q <= tx_start_d;
         cpu_en_q   <= cpu_en_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      byte_d     = byte_q;
      shift_d    = shift_q;
      w_data_d   = w_data_q;
      tx_start_d = 1'b0;
      cpu_en_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (rx_done) begin
               if (r_data == CMD_DUMP) begin
                  state_d = S_RD_ADDR;
                  word_d  = '0;
               end else if (r_data == CMD_RUN || r_data == CMD_STEP) begin
                  word_d = '0;
                  if (cpu_halted) begin
                     state_d = S_RD_ADDR;
                  end else begin
                     state_d  = (r_data == CMD_RUN) ? S_RUN : S_STEP;
                     cpu_en_d = 1'b1;
                  end
               end
            end
         end
         S_RUN: begin
            if (cpu_halted) begin
               state_d = S_RD_ADDR;
            end else begin
               cpu_en_d = 1'b1;
            end
         end
         S_STEP: begin
            state_d = S_RD_ADDR;
         end
         S_RD_ADDR: begin
            state_d = S_RD_WAIT;
         end
         // dump_addr follows word_q, so the address is already registered on
         // entry to RD_ADDR and the synchronous read is valid during RD_WAIT.
         S_RD_WAIT: begin
            shift_d = dump_data;
            byte_d  = '0;
            state_d = S_SEND;
         end
         S_SEND: begin
            w_data_d   = shift_q[31:24];
            shift_d    = {shift_q[23:0], 8'h00};
            tx_start_d = 1'b1;
            state_d    = S_WAIT_TX;
         end
         S_WAIT_TX: begin
            if (tx_done) begin
               if (byte_q != 2'd3) begin
                  byte_d  = byte_q + 2'd1;
                  state_d = S_SEND;
               end else if (word_q != LAST_WORD) begin
                  word_d  = word_q + 1'b1;
                  state_d = S_RD_ADDR;
               end else begin
                  state_d = S_TERM;
               end
            end
         end
         S_TERM: begin
            w_data_d   = TERM_BYTE;
            tx_start_d = 1'b1;
            state_d    = S_TERM_WAIT;
         end
         S_TERM_WAIT: begin
            if (tx_done) begin
               state_d = S_IDLE;
               word_d  = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign tx_start  = tx_start_q;
   assign w_data    = w_data_q;
   assign cpu_en    = cpu_en_q;
   assign dump_addr = word_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// tb_uart_debug_ctrl: randomized bench for uart_debug_ctrl with uart, core
// and dump-memory models and a byte-stream reference model.
module tb_uart_debug_ctrl;

   localparam int NW   = 32;
   localparam int NB   = 4 * NW + 1;
   localparam logic [7:0] C_RUN  = 8'h63;
   localparam logic [7:0] C_STEP = 8'h73;
   localparam logic [7:0] C_DUMP = 8'h64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_done = 1'b0;
   logic [7:0]  r_data = 8'h00;
   logic        tx_done = 1'b0;
   logic        tx_start;
   logic [7:0]  w_data;
   logic        cpu_en;
   logic        cpu_halted = 1'b0;
   logic [4:0]  dump_addr;
   logic [31:0] dump_data = 32'h0;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [7:0]  rx_q[$];
   int          n_tx = 0;
   int          en_cycles = 0;
   logic [31:0] base = 32'hA0B0C000;
   bit          force_halt = 1'b0;
   bit          halt_arm = 1'b0;
   int          halt_at = 0;
   bit          outstanding = 1'b0;
   logic [7:0]  held = 8'h00;
   int          dly = 0;

   uart_debug_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .rx_done    (rx_done),
      .r_data     (r_data),
      .tx_done    (tx_done),
      .tx_start   (tx_start),
      .w_data     (w_data),
      .cpu_en     (cpu_en),
      .cpu_halted (cpu_halted),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // dump source: synchronous read, word[i] = base + i
   always @(posedge clk) dump_data <= base + 32'(dump_addr);

   // uart and core models, sampled on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (cpu_en === 1'b1) en_cycles++;
         cpu_halted = force_halt || (halt_arm && en_cycles >= halt_at);
         if (rst) begin
            outstanding = 1'b0;
         end else if (tx_start === 1'b1) begin
            checks++;
            if (outstanding) begin
               errors++;
               $display("FAIL tx_overlap: tx_start=1 while byte outstanding, required 0");
            end
            rx_q.push_back(w_data);
            n_tx++;
            outstanding = 1'b1;
            held = w_data;
            dly = $urandom_range(2, 8);
         end else if (outstanding) begin
            checks++;
            if (w_data !== held) begin
               errors++;
               $display("FAIL w_data_hold: got %h required %h", w_data, held);
            end
            dly--;
            if (dly == 0) begin
               tx_done = 1'b1;
               outstanding = 1'b0;
            end
         end
      end
   end

   // reference: byte k of a dump frame starting at stream index q0
   function automatic logic [7:0] exp_byte(int k);
      logic [31:0] w;
      if (k == 4 * NW) return 8'h0A;
      w = base + 32'(k / 4);
      return 8'(w >> (8 * (3 - (k % 4))));
   endfunction

   function automatic int first_bad(int q0);
      for (int k = 0; k < NB; k++) begin
         if (q0 + k >= rx_q.size()) return k;
         if (rx_q[q0 + k] !== exp_byte(k)) return k;
      end
      return -1;
   endfunction

   task automatic send_cmd(input logic [7:0] c);
      @(negedge clk);
      r_data = c;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      r_data = 8'($urandom);
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_start, w_data, cpu_en, dump_addr, busy} !== 16'h0) begin
         errors++;
         $display("FAIL reset: got ts=%b wd=%h en=%b ad=%h bz=%b required all 0",
                  tx_start, w_data, cpu_en, dump_addr, busy);
      end
      rst = 1'b0;
   endtask

   // generic run of one command and check of cpu_en cycles and dump frame
   task automatic run_and_check(input string nm, input logic [7:0] c,
                                input bit halted, input int hlt_after);
      int q0, e0, bad, exp_en;
      bit ok;
      force_halt = halted;
      halt_arm = 1'b0;
      q0 = rx_q.size();
      e0 = en_cycles;
      if (hlt_after > 0) begin
         halt_at = e0 + hlt_after;
         halt_arm = 1'b1;
      end
      exp_en = halted ? 0 : (c == C_RUN) ? hlt_after : (c == C_STEP) ? 1 : 0;
      send_cmd(c);
      wait_idle(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_timeout: busy still 1, required 0", nm);
      end
      checks++;
      if (en_cycles - e0 !== exp_en) begin
         errors++;
         $display("FAIL %s_cpu_en: got %0d cycles required %0d", nm, en_cycles - e0, exp_en);
      end
      checks++;
      if (rx_q.size() - q0 !== NB) begin
         errors++;
         $display("FAIL %s_len: got %0d bytes required %0d", nm, rx_q.size() - q0, NB);
      end
      bad = first_bad(q0);
      checks++;
      if (bad !== -1) begin
         errors++;
         $display("FAIL %s_data: byte %0d got %h required %h", nm, bad,
                  (q0 + bad < rx_q.size()) ? rx_q[q0 + bad] : 8'hxx, exp_byte(bad));
      end
      halt_arm = 1'b0;
      force_halt = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_dump();
      base = 32'hA0B0C000;
      run_and_check("dump", C_DUMP, 1'b0, 0);
   endtask

   task automatic test_run();
      base = $urandom;
      run_and_check("run40", C_RUN, 1'b0, 40);
      base = $urandom;
      run_and_check("run_rand", C_RUN, 1'b0, $urandom_range(1, 60));
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL run_busy: got %b required 0", busy);
      end
   endtask

   task automatic test_step();
      base = $urandom;
      run_and_check("step1", C_STEP, 1'b0, 0);
      base = $urandom;
      run_and_check("step2", C_STEP, 1'b0, 0);
   endtask

   task automatic test_halted();
      base = $urandom;
      run_and_check("halt_s", C_STEP, 1'b1, 0);
      base = $urandom;
      run_and_check("halt_c", C_RUN, 1'b1, 0);
   endtask

   task automatic test_ignore();
      int t0, bz, q0, bad;
      logic [7:0] b;
      bit ok;
      t0 = n_tx;
      bz = 0;
      send_cmd(8'h00);
      send_cmd(8'hFF);
      send_cmd(8'h44);
      for (int i = 0; i < 6; i++) begin
         do b = 8'($urandom); while (b == C_RUN || b == C_STEP || b == C_DUMP);
         send_cmd(b);
         if (busy) bz++;
      end
      repeat (5) begin
         @(negedge clk);
         if (busy) bz++;
      end
      checks++;
      if (n_tx - t0 !== 0 || bz !== 0) begin
         errors++;
         $display("FAIL ignore_idle: got %0d tx / %0d busy cycles required 0/0", n_tx - t0, bz);
      end
      base = $urandom;
      t0 = n_tx;
      q0 = rx_q.size();
      send_cmd(C_DUMP);
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(5, 60)) @(negedge clk);
         send_cmd((i % 2 == 0) ? C_DUMP : C_RUN);
      end
      wait_idle(ok);
      checks++;
      if (!ok || n_tx - t0 !== NB) begin
         errors++;
         $display("FAIL ignore_busy: got %0d tx_start required %0d", n_tx - t0, NB);
      end
      bad = first_bad(q0);
      checks++;
      if (bad !== -1) begin
         errors++;
         $display("FAIL ignore_data: first bad byte %0d required none", bad);
      end
   endtask

   task automatic test_rst_mid();
      bit hit;
      int t0;
      base = $urandom;
      t0 = n_tx;
      send_cmd(C_DUMP);
      hit = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (n_tx - t0 >= 4 * 7 + 1) begin
            hit = 1'b1;
            break;
         end
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL rst_mid_reach: got %0d bytes required %0d", n_tx - t0, 29);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({tx_start, w_data, cpu_en, dump_addr, busy} !== 16'h0) begin
         errors++;
         $display("FAIL rst_mid_out: got ts=%b wd=%h en=%b ad=%h bz=%b required all 0",
                  tx_start, w_data, cpu_en, dump_addr, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      t0 = n_tx;
      repeat (40) @(negedge clk);
      checks++;
      if (n_tx - t0 !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_quiet: got %0d tx busy=%b required 0 tx busy=0", n_tx - t0, busy);
      end
      base = $urandom;
      run_and_check("rst_restart", C_DUMP, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] c;
      int r;
      for (int i = 0; i < 4; i++) begin
         r = $urandom_range(0, 2);
         c = (r == 0) ? C_RUN : (r == 1) ? C_STEP : C_DUMP;
         base = $urandom;
         run_and_check("b2b", c, 1'($urandom_range(0, 1)),
                       (c == C_RUN) ? $urandom_range(1, 50) : 0);
      end
   endtask

   initial begin
      test_reset();
      test_dump();
      test_run();
      test_step();
      test_halted();
      test_ignore();
      test_rst_mid();
      do_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
